sha3_sponge_ctrl: RTL and testbench

//  Sponge sequencer for the Keccak-f[1600] permutation core. Packs a byte-granular

---
 rtl/sha3_sponge_ctrl.sv | 214 +++++++++++++++++++++
 tb/tb_sha3_sponge_ctrl.sv | 400 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sha3_sponge_ctrl.sv
// SHA-3 sponge sequencer: packs byte lanes into rate blocks, applies 0x06..0x80 padding,
// hands blocks to the Keccak core and streams the digest lanes back out.
module sha3_sponge_ctrl #(
  parameter int WIDTH      = 64,
  parameter int RATE_LANES = 17,
  parameter int OUT_LANES  = 4
) (
  input  logic                          clk,
  input  logic                          nrst,
  input  logic [WIDTH-1:0]              in_data,
  input  logic [3:0]                    in_bytes,
  input  logic                          in_last,
  input  logic                          in_valid,
  output logic                          in_ready,
  output logic [RATE_LANES*WIDTH-1:0]   blk_data,
  output logic                          blk_last,
  output logic                          blk_valid,
  input  logic                          blk_ready,
  input  logic                          core_done,
  input  logic [OUT_LANES*WIDTH-1:0]    core_state,
  output logic [WIDTH-1:0]              dig_data,
  output logic                          dig_last,
  output logic                          dig_valid,
  input  logic                          dig_ready,
  output logic                          busy
);

  localparam int LANE_BYTES = WIDTH / 8;
  localparam int LCW        = $clog2(RATE_LANES + 1);
  localparam int BYW        = (LANE_BYTES > 1) ? $clog2(LANE_BYTES) : 1;
  localparam int DCW        = (OUT_LANES > 1) ? $clog2(OUT_LANES) : 1;

  localparam logic [LCW-1:0] LAST_LANE  = LCW'(RATE_LANES - 1);
  localparam logic [DCW-1:0] LAST_DIG   = DCW'(OUT_LANES - 1);
  localparam logic [3:0]     FULL_BYTES = 4'(LANE_BYTES);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FILL,
    S_PAD,
    S_ISSUE,
    S_WAIT,
    S_SQUEEZE
  } state_e;

  state_e           state_q, state_d;
  logic [LCW-1:0]   lane_cnt_q, lane_cnt_d;
  logic [WIDTH-1:0] buf_q [RATE_LANES];
  logic [WIDTH-1:0] buf_d [RATE_LANES];
  logic             pad_pending_q, pad_pending_d;
  logic [LCW-1:0]   pad_lane_q, pad_lane_d;
  logic [BYW-1:0]   pad_byte_q, pad_byte_d;
  logic             blk_last_q, blk_last_d;
  logic [WIDTH-1:0] dig_q [OUT_LANES];
  logic [WIDTH-1:0] dig_d [OUT_LANES];
  logic [DCW-1:0]   dig_cnt_q, dig_cnt_d;

  logic [3:0]       bytes_eff;
  logic [WIDTH-1:0] in_masked;
  logic             in_fire;

  // Byte count only matters on the last word; anything above a full lane saturates.
  always_comb begin
    bytes_eff = FULL_BYTES;
    if (in_last && (in_bytes < FULL_BYTES)) begin
      bytes_eff = in_bytes;
    end
    in_masked = '0;
    for (int b = 0; b < LANE_BYTES; b++) begin
      if (b < int'(bytes_eff)) begin
        in_masked[b*8 +: 8] = in_data[b*8 +: 8];
      end
    end
  end

  assign in_ready = (state_q == S_IDLE) || (state_q == S_FILL);
  assign in_fire  = in_valid && in_ready;

  always_comb begin
    state_d       = state_q;
    lane_cnt_d    = lane_cnt_q;
    buf_d         = buf_q;
    pad_pending_d = pad_pending_q;
    pad_lane_d    = pad_lane_q;
    pad_byte_d    = pad_byte_q;
    blk_last_d    = blk_last_q;
    dig_d         = dig_q;
    dig_cnt_d     = dig_cnt_q;

    case (state_q)
      S_IDLE, S_FILL: begin
        if (in_fire) begin
          buf_d[lane_cnt_q] = in_masked;
          lane_cnt_d        = lane_cnt_q + LCW'(1);
          if (in_last) begin
            if (bytes_eff == FULL_BYTES) begin
              // A full final lane pushes the pad marker to the next lane, or to a fresh block.
              if (lane_cnt_q == LAST_LANE) begin
                pad_pending_d = 1'b1;
                pad_lane_d    = '0;
                pad_byte_d    = '0;
                blk_last_d    = 1'b0;
                state_d       = S_ISSUE;
              end else begin
                pad_lane_d = lane_cnt_q + LCW'(1);
                pad_byte_d = '0;
                state_d    = S_PAD;
              end
            end else begin
              pad_lane_d = lane_cnt_q;
              pad_byte_d = BYW'(bytes_eff);
              state_d    = S_PAD;
            end
          end else if (lane_cnt_q == LAST_LANE) begin
            blk_last_d = 1'b0;
            state_d    = S_ISSUE;
          end else begin
            state_d = S_FILL;
          end
        end
      end

      S_PAD: begin
        buf_d[pad_lane_q][int'(pad_byte_q)*8 +: 8] =
          buf_q[pad_lane_q][int'(pad_byte_q)*8 +: 8] | 8'h06;
        buf_d[RATE_LANES-1][WIDTH-1 -: 8] = buf_d[RATE_LANES-1][WIDTH-1 -: 8] | 8'h80;
        blk_last_d    = 1'b1;
        pad_pending_d = 1'b0;
        state_d       = S_ISSUE;
      end

      S_ISSUE: begin
        if (blk_ready) begin
          for (int i = 0; i < RATE_LANES; i++) begin
            buf_d[i] = '0;
          end
          lane_cnt_d = '0;
          blk_last_d = 1'b0;
          if (pad_pending_q) begin
            state_d = S_PAD;
          end else if (blk_last_q) begin
            state_d = S_WAIT;
          end else begin
            state_d = S_FILL;
          end
        end
      end

      S_WAIT: begin
        if (core_done) begin
          for (int k = 0; k < OUT_LANES; k++) begin
            dig_d[k] = core_state[k*WIDTH +: WIDTH];
          end
          dig_cnt_d = '0;
          state_d   = S_SQUEEZE;
        end
      end

      S_SQUEEZE: begin
        if (dig_ready) begin
          if (dig_cnt_q == LAST_DIG) begin
            state_d = S_IDLE;
          end else begin
            dig_cnt_d = dig_cnt_q + DCW'(1);
          end
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q       <= S_IDLE;
      lane_cnt_q    <= '0;
      pad_pending_q <= 1'b0;
      pad_lane_q    <= '0;
      pad_byte_q    <= '0;
      blk_last_q    <= 1'b0;
      dig_cnt_q     <= '0;
      for (int i = 0; i < RATE_LANES; i++) begin
        buf_q[i] <= '0;
      end
      for (int k = 0; k < OUT_LANES; k++) begin
        dig_q[k] <= '0;
      end
    end else begin
      state_q       <= state_d;
      lane_cnt_q    <= lane_cnt_d;
      pad_pending_q <= pad_pending_d;
      pad_lane_q    <= pad_lane_d;
      pad_byte_q    <= pad_byte_d;
      blk_last_q    <= blk_last_d;
      dig_cnt_q     <= dig_cnt_d;
      buf_q         <= buf_d;
      dig_q         <= dig_d;
    end
  end

  for (genvar i = 0; i < RATE_LANES; i++) begin : g_blk
    assign blk_data[i*WIDTH +: WIDTH] = buf_q[i];
  end

  assign blk_last  = blk_last_q;
  assign blk_valid = (state_q == S_ISSUE);
  assign dig_valid = (state_q == S_SQUEEZE);
  assign dig_last  = dig_valid && (dig_cnt_q == LAST_DIG);
  assign dig_data  = dig_q[dig_cnt_q];
  assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_sha3_sponge_ctrl.sv
// Randomized bench for sha3_sponge_ctrl: a byte-level SHA-3 padding model predicts every
// block, a toy core supplies digest states, and a negedge monitor compares the streams.
`timescale 1ns/1ps
module tb_sha3_sponge_ctrl;

  localparam int W  = 64;
  localparam int RL = 17;
  localparam int OL = 4;
  localparam int BB = RL * W / 8;

  typedef logic [7:0] bq_t[$];
  typedef struct { logic [RL*W-1:0] data; logic last; } blk_t;
  typedef struct { logic [W-1:0] data; logic last; } dig_t;

  logic              clk;
  logic              nrst;
  logic [W-1:0]      in_data;
  logic [3:0]        in_bytes;
  logic              in_last;
  logic              in_valid;
  logic              in_ready;
  logic [RL*W-1:0]   blk_data;
  logic              blk_last;
  logic              blk_valid;
  logic              blk_ready;
  logic              core_done;
  logic [OL*W-1:0]   core_state;
  logic [W-1:0]      dig_data;
  logic              dig_last;
  logic              dig_valid;
  logic              dig_ready;
  logic              busy;

  blk_t exp_blk[$];
  dig_t exp_dig[$];

  int checks = 0;
  int passes = 0;
  int blk_count = 0;
  logic [RL*W-1:0] last_blk;
  logic            last_blk_last;
  bit core_en = 1;
  bit blk_stall = 0;
  bit dig_stall = 0;

  sha3_sponge_ctrl #(.WIDTH(W), .RATE_LANES(RL), .OUT_LANES(OL)) dut (
    .clk(clk), .nrst(nrst),
    .in_data(in_data), .in_bytes(in_bytes), .in_last(in_last),
    .in_valid(in_valid), .in_ready(in_ready),
    .blk_data(blk_data), .blk_last(blk_last), .blk_valid(blk_valid), .blk_ready(blk_ready),
    .core_done(core_done), .core_state(core_state),
    .dig_data(dig_data), .dig_last(dig_last), .dig_valid(dig_valid), .dig_ready(dig_ready),
    .busy(busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #900000;
    $display("[TB] FAIL watchdog: got no finish, expected end of run");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [RL*W-1:0] act,
                             input logic [RL*W-1:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // SHA-3 padding on the byte string, then cut into rate-sized blocks.
  task automatic modelMessage(input bq_t m);
    int n = m.size();
    int total = (n / BB + 1) * BB;
    logic [7:0] p[];
    p = new[total];
    for (int i = 0; i < total; i++) p[i] = (i < n) ? m[i] : 8'h00;
    p[n] = p[n] | 8'h06;
    p[total-1] = p[total-1] | 8'h80;
    for (int b = 0; b < total / BB; b++) begin
      blk_t e;
      e.data = '0;
      for (int i = 0; i < BB; i++) e.data[i*8 +: 8] = p[b*BB + i];
      e.last = (b == total / BB - 1);
      exp_blk.push_back(e);
    end
  endtask

  function automatic bq_t randMsg(input int n);
    bq_t m;
    for (int i = 0; i < n; i++) m.push_back(8'($urandom));
    return m;
  endfunction

  task automatic sendWord(input logic [W-1:0] d, input logic [3:0] b, input logic l);
    bit ok;
    int guard = 0;
    in_data = d; in_bytes = b; in_last = l; in_valid = 1'b1;
    do begin
      ok = in_ready;
      @(negedge clk);
      guard++;
    end while (!ok && guard < 2000);
    checkOutput("in_accept_in_time", ok, 1);
    in_valid = 1'b0;
  endtask

  task automatic applyStimulus(input bq_t m, input bit extra_zero);
    int n = m.size();
    int nw, lastb, lane, d;
    logic [W-1:0] data;
    logic [3:0] nbf;
    if (n == 0) begin nw = 1; lastb = 0; end
    else begin nw = (n + 7) / 8; lastb = n - (nw - 1) * 8; end
    if (extra_zero && n > 0 && lastb == 8) begin nw++; lastb = 0; end
    for (int w = 0; w < nw; w++) begin
      int nb = (w == nw - 1) ? lastb : 8;
      data = {$urandom, $urandom};
      for (int b = 0; b < nb; b++) data[b*8 +: 8] = m[w*8 + b];
      if (w == nw - 1) nbf = (lastb == 8 && $urandom_range(0, 1) == 1) ? 4'($urandom_range(9, 15)) : 4'(lastb);
      else nbf = 4'($urandom);
      lane = w % RL;
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
      sendWord(data, nbf, w == nw - 1);
      if (w == nw - 1) d = (lastb == 8 && lane == RL - 1) ? 1 : 2;
      else d = (lane == RL - 1) ? 1 : 0;
      if (d == 1) checkOutput("blk_valid_after_full", blk_valid, 1);
      if (d == 2) begin
        checkOutput("blk_valid_pad_cycle", blk_valid, 0);
        @(negedge clk);
        checkOutput("blk_valid_after_pad", blk_valid, 1);
      end
    end
  endtask

  task automatic waitIdle();
    int g = 0;
    while ((busy || exp_dig.size() != 0) && g < 3000) begin
      @(negedge clk);
      g++;
    end
    checkOutput("drain_in_time", g < 3000, 1);
    checkOutput("blocks_all_issued", exp_blk.size(), 0);
    checkOutput("digest_all_out", exp_dig.size(), 0);
  endtask

  task automatic resetPulse(input string tag);
    @(negedge clk);
    #2 nrst = 1'b0;
    #1;
    checkOutput({tag, "_blk_valid"}, blk_valid, 0);
    checkOutput({tag, "_blk_last"}, blk_last, 0);
    checkOutput({tag, "_blk_data"}, blk_data, 0);
    checkOutput({tag, "_dig_valid"}, dig_valid, 0);
    checkOutput({tag, "_dig_last"}, dig_last, 0);
    checkOutput({tag, "_dig_data"}, dig_data, 0);
    checkOutput({tag, "_busy"}, busy, 0);
    @(negedge clk);
    nrst = 1'b1;
    exp_blk.delete();
    exp_dig.delete();
  endtask

  // Ready signals change just after the rising edge so they are settled for the monitor.
  initial begin
    blk_ready = 1'b0;
    dig_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      blk_ready = !blk_stall && ($urandom_range(0, 3) != 0);
      dig_ready = !dig_stall && ($urandom_range(0, 2) != 0);
    end
  end

  // Toy core: answers a final block with a random state; also fires stray done pulses while idle/filling.
  initial begin
    core_done = 1'b0;
    core_state = '0;
    forever begin
      @(negedge clk);
      core_done = 1'b0;
      if (core_en && nrst && blk_valid && blk_ready && blk_last) begin
        repeat ($urandom_range(1, 6)) @(negedge clk);
        for (int k = 0; k < OL * W / 32; k++) core_state[k*32 +: 32] = $urandom;
        core_done = 1'b1;
        for (int k = 0; k < OL; k++) begin
          dig_t dd;
          dd.data = core_state[k*W +: W];
          dd.last = (k == OL - 1);
          exp_dig.push_back(dd);
        end
      end else if (in_ready && $urandom_range(0, 5) == 0) begin
        for (int k = 0; k < OL * W / 32; k++) core_state[k*32 +: 32] = $urandom;
        core_done = 1'b1;
      end
    end
  end

  blk_t mb;
  dig_t md;
  logic [RL*W-1:0] prev_blk;
  logic prev_blk_last;
  bit blk_hold = 0;
  logic [W-1:0] prev_dig;
  logic prev_dig_last;
  bit dig_hold = 0;

  initial begin
    forever begin
      @(negedge clk);
      if (!nrst) begin
        blk_hold = 0;
        dig_hold = 0;
      end else begin
        if (blk_valid) begin
          checkOutput("in_ready_while_blk", in_ready, 0);
          if (blk_hold) begin
            checkOutput("blk_data_stable", blk_data, prev_blk);
            checkOutput("blk_last_stable", blk_last, prev_blk_last);
          end
          if (blk_ready) begin
            checkOutput("blk_was_expected", exp_blk.size() != 0, 1);
            if (exp_blk.size() != 0) begin
              mb = exp_blk.pop_front();
              checkOutput("blk_data", blk_data, mb.data);
              checkOutput("blk_last", blk_last, mb.last);
            end
            last_blk = blk_data;
            last_blk_last = blk_last;
            blk_count++;
            blk_hold = 0;
          end else begin
            blk_hold = 1;
            prev_blk = blk_data;
            prev_blk_last = blk_last;
          end
        end else blk_hold = 0;

        if (dig_valid) begin
          checkOutput("in_ready_while_dig", in_ready, 0);
          if (dig_hold) begin
            checkOutput("dig_data_stable", dig_data, prev_dig);
            checkOutput("dig_last_stable", dig_last, prev_dig_last);
          end
          if (dig_ready) begin
            checkOutput("dig_was_expected", exp_dig.size() != 0, 1);
            if (exp_dig.size() != 0) begin
              md = exp_dig.pop_front();
              checkOutput("dig_data", dig_data, md.data);
              checkOutput("dig_last", dig_last, md.last);
            end
            dig_hold = 0;
          end else begin
            dig_hold = 1;
            prev_dig = dig_data;
            prev_dig_last = dig_last;
          end
        end else dig_hold = 0;
      end
    end
  end

  bq_t m;
  bq_t abc;
  logic [RL*W-1:0] lit_empty;
  logic [RL*W-1:0] lit_abc;
  int b0;
  int g;

  initial begin
    nrst = 1'b1;
    in_valid = 1'b0; in_data = '0; in_bytes = '0; in_last = 1'b0;
    #1 nrst = 1'b0;
    #1;
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_blk_valid", blk_valid, 0);
    checkOutput("rst_blk_last", blk_last, 0);
    checkOutput("rst_blk_data", blk_data, 0);
    checkOutput("rst_dig_valid", dig_valid, 0);
    checkOutput("rst_dig_last", dig_last, 0);
    checkOutput("rst_dig_data", dig_data, 0);
    checkOutput("rst_in_ready", in_ready, 1);
    repeat (2) @(negedge clk);
    nrst = 1'b1;

    lit_empty = '0;
    lit_empty[63:0] = 64'h06;
    lit_empty[RL*W-1 -: 64] = 64'h8000_0000_0000_0000;
    lit_abc = lit_empty;
    lit_abc[63:0] = 64'h0000_0000_0663_6261;
    abc = {8'h61, 8'h62, 8'h63};

    $display("[TB] T1 empty message");
    m.delete();
    modelMessage(m);
    checkOutput("T1_model_block", exp_blk[$].data, lit_empty);
    b0 = blk_count;
    applyStimulus(m, 0);
    waitIdle();
    checkOutput("T1_block", last_blk, lit_empty);
    checkOutput("T1_block_last", last_blk_last, 1);
    checkOutput("T1_block_count", blk_count - b0, 1);

    $display("[TB] T2 abc");
    modelMessage(abc);
    checkOutput("T2_model_block", exp_blk[$].data, lit_abc);
    b0 = blk_count;
    applyStimulus(abc, 0);
    waitIdle();
    checkOutput("T2_block", last_blk, lit_abc);
    checkOutput("T2_block_count", blk_count - b0, 1);

    $display("[TB] T3 136 bytes");
    m = randMsg(136);
    modelMessage(m);
    checkOutput("T3_model_nblocks", exp_blk.size(), 2);
    checkOutput("T3_model_first_last", exp_blk[0].last, 0);
    checkOutput("T3_model_pad_block", exp_blk[1].data, lit_empty);
    b0 = blk_count;
    applyStimulus(m, 0);
    waitIdle();
    checkOutput("T3_block_count", blk_count - b0, 2);
    checkOutput("T3_pad_block", last_blk, lit_empty);
    checkOutput("T3_pad_block_last", last_blk_last, 1);

    $display("[TB] T4 135 bytes");
    m = randMsg(135);
    modelMessage(m);
    checkOutput("T4_model_top_byte", exp_blk[0].data[RL*W-1 -: 8], 8'h86);
    b0 = blk_count;
    applyStimulus(m, 0);
    waitIdle();
    checkOutput("T4_block_count", blk_count - b0, 1);
    checkOutput("T4_top_byte", last_blk[RL*W-1 -: 8], 8'h86);

    $display("[TB] T5 back-pressure");
    blk_stall = 1; dig_stall = 1;
    m = randMsg(20);
    modelMessage(m);
    applyStimulus(m, 0);
    repeat (5) begin
      @(negedge clk);
      checkOutput("T5_blk_valid_held", blk_valid, 1);
      checkOutput("T5_in_ready_low", in_ready, 0);
    end
    blk_stall = 0;
    g = 0;
    while (!dig_valid && g < 500) begin @(negedge clk); g++; end
    checkOutput("T5_dig_valid_seen", dig_valid, 1);
    repeat (3) begin
      @(negedge clk);
      checkOutput("T5_dig_valid_held", dig_valid, 1);
      checkOutput("T5_in_ready_low_dig", in_ready, 0);
    end
    dig_stall = 0;
    waitIdle();

    $display("[TB] T6 reset in WAIT and SQUEEZE");
    core_en = 0;
    modelMessage(abc);
    applyStimulus(abc, 0);
    g = 0;
    while (exp_blk.size() != 0 && g < 500) begin @(negedge clk); g++; end
    repeat (2) @(negedge clk);
    checkOutput("T6_wait_busy", busy, 1);
    checkOutput("T6_wait_no_dig", dig_valid, 0);
    resetPulse("T6_wait");
    core_en = 1;
    dig_stall = 1;
    modelMessage(abc);
    applyStimulus(abc, 0);
    g = 0;
    while (!dig_valid && g < 500) begin @(negedge clk); g++; end
    checkOutput("T6_squeeze_reached", dig_valid, 1);
    resetPulse("T6_squeeze");
    dig_stall = 0;
    modelMessage(abc);
    b0 = blk_count;
    applyStimulus(abc, 0);
    waitIdle();
    checkOutput("T6_after_block", last_blk, lit_abc);
    checkOutput("T6_after_count", blk_count - b0, 1);

    $display("[TB] random messages");
    for (int r = 0; r < 20; r++) begin
      m = randMsg($urandom_range(0, 300));
      modelMessage(m);
      applyStimulus(m, $urandom_range(0, 1) == 1);
      waitIdle();
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
